// File: rtl/key_debounce.sv
// Active-low push-button conditioner: 2-flop synchroniser, per-key debounce FSM,
// registered level plus single-cycle press/release/long-press pulses.
module key_debounce #(
  parameter int KEY_W           = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_n,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
  localparam bit LONG_EN = (LONG_CYCLES > 0);
  // The entering sample already counts as 1, so a check completes once the
  // stored count reaches DEBOUNCE_CYCLES-1 on a further agreeing sample.
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'((LONG_CYCLES > 0) ? LONG_CYCLES : 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_UP     = 2'd0,
    S_DN_CHK = 2'd1,
    S_DOWN   = 2'd2,
    S_UP_CHK = 2'd3
  } state_t;

  logic [KEY_W-1:0] r_sync1;
  logic [KEY_W-1:0] r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < KEY_W; gi++) begin : g_key
      state_t            r_state, w_state_next;
      logic [DEB_W-1:0]  r_deb, w_deb_next;
      logic [HOLD_W-1:0] r_hold, w_hold_next, w_hold_inc;
      logic              r_long_done, w_long_done_next;
      logic              r_level, w_level_next;
      logic              r_press, w_press_next;
      logic              r_release, w_release_next;
      logic              r_long, w_long_next;
      logic              w_s;
      logic              w_deb_done;
      logic              w_long_fire;

      assign w_s         = r_sync2[gi];
      assign w_deb_done  = (r_deb >= DEB_LAST);
      assign w_hold_inc  = (r_hold != HOLD_MAX) ? r_hold + 1'b1 : r_hold;
      assign w_long_fire = LONG_EN && !r_long_done && (r_hold == HOLD_FIRE);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state     <= S_UP;
          r_deb       <= '0;
          r_hold      <= '0;
          r_long_done <= 1'b0;
          r_level     <= 1'b0;
          r_press     <= 1'b0;
          r_release   <= 1'b0;
          r_long      <= 1'b0;
        end else begin
          r_state     <= w_state_next;
          r_deb       <= w_deb_next;
          r_hold      <= w_hold_next;
          r_long_done <= w_long_done_next;
          r_level     <= w_level_next;
          r_press     <= w_press_next;
          r_release   <= w_release_next;
          r_long      <= w_long_next;
        end
      end

      always_comb begin
        w_state_next     = r_state;
        w_deb_next       = r_deb;
        w_hold_next      = r_hold;
        w_long_done_next = r_long_done;
        w_level_next     = r_level;
        w_press_next     = 1'b0;
        w_release_next   = 1'b0;
        w_long_next      = 1'b0;
        case (r_state)
          S_UP: begin
            if (!w_s) begin
              w_state_next = S_DN_CHK;
              w_deb_next   = DEB_W'(1);
            end
          end
          S_DN_CHK: begin
            if (w_s) begin
              w_state_next = S_UP;
              w_deb_next   = '0;
            end else if (w_deb_done) begin
              w_state_next     = S_DOWN;
              w_deb_next       = '0;
              w_level_next     = 1'b1;
              w_press_next     = 1'b1;
              w_hold_next      = '0;
              w_long_done_next = 1'b0;
            end else begin
              w_deb_next = r_deb + 1'b1;
            end
          end
          S_DOWN: begin
            if (w_s) begin
              w_state_next = S_UP_CHK;
              w_deb_next   = DEB_W'(1);
            end else begin
              w_hold_next = w_hold_inc;
              if (w_long_fire) begin
                w_long_next      = 1'b1;
                w_long_done_next = 1'b1;
              end
            end
          end
          S_UP_CHK: begin
            // A low sample here is a held-key sample, so it advances the hold count.
            if (!w_s) begin
              w_state_next = S_DOWN;
              w_deb_next   = '0;
              w_hold_next  = w_hold_inc;
              if (w_long_fire) begin
                w_long_next      = 1'b1;
                w_long_done_next = 1'b1;
              end
            end else if (w_deb_done) begin
              w_state_next   = S_UP;
              w_deb_next     = '0;
              w_level_next   = 1'b0;
              w_release_next = 1'b1;
            end else begin
              w_deb_next = r_deb + 1'b1;
            end
          end
          default: w_state_next = S_UP;
        endcase
      end

      assign key_level[gi]   = r_level;
      assign key_press[gi]   = r_press;
      assign key_release[gi] = r_release;
      assign key_long[gi]    = r_long;
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected pulses with their
// edge number, a negedge monitor pops and compares every pulse the DUT emits.
module tb_key_debounce;

  localparam int KW = 2;
  localparam int DB = 4;
  localparam int LG = 10;
  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  logic          clk;
  logic          rst_n;
  logic [KW-1:0] key_n;
  logic [KW-1:0] key_level;
  logic [KW-1:0] key_press;
  logic [KW-1:0] key_release;
  logic [KW-1:0] key_long;

  key_debounce #(.KEY_W(KW), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  typedef struct {
    int cyc;
    int key;
    int kind;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(input int kind);
    case (kind)
      K_PRESS: return "press";
      K_REL:   return "release";
      default: return "long";
    endcase
  endfunction

  task automatic push(input int c, input int k, input int kind);
    exp_t e;
    e.cyc  = c;
    e.key  = k;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k, input int kind);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL pulse_unexpected: got %s key%0d at edge %0d, expected none",
               kind_name(kind), k, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.key != k || e.kind != kind) begin
        n_err++;
        $display("FAIL pulse_match: got %s key%0d at edge %0d, expected %s key%0d at edge %0d",
                 kind_name(kind), k, cyc, kind_name(e.kind), e.key, e.cyc);
      end else begin
        $display("ok   %s key%0d at edge %0d", kind_name(kind), k, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < KW; k++) begin
      if (key_press[k])   observe(k, K_PRESS);
      if (key_release[k]) observe(k, K_REL);
      if (key_long[k])    observe(k, K_LONG);
    end
  end

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at edge %0d", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %b at edge %0d", name, act, cyc);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_level"},   key_level,   2'b00);
    chk({name, "_press"},   key_press,   2'b00);
    chk({name, "_release"}, key_release, 2'b00);
    chk({name, "_long"},    key_long,    2'b00);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int m;
    int p;
    logic [4:0] pat;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    key_n = '1;
    tick(3);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;
    tick(3);
    #1 chk("after_reset_level", key_level, 2'b00);

    // Clean press on key0, then clean release.
    tick(1);
    k = cyc;
    key_n[0] = 1'b0;
    push(k + DB + 2, 0, K_PRESS);
    tick(5);
    #1 chk("clean_level_before", key_level, 2'b00);
    tick(1);
    #1 chk("clean_level_pressed", key_level, 2'b01);
    tick(2);
    m = cyc;
    key_n[0] = 1'b1;
    push(m + DB + 2, 0, K_REL);
    tick(7);
    #1 chk("clean_level_released", key_level, 2'b00);

    // Bouncy press, then a long hold and release.
    tick(2);
    k = cyc;
    pat = 5'b10010;
    for (int i = 0; i < 5; i++) begin
      key_n[0] = pat[i];
      tick(1);
    end
    key_n[0] = 1'b0;
    p = cyc + DB + 2;
    push(p, 0, K_PRESS);
    push(p + LG, 0, K_LONG);
    tick(21);
    #1 chk("long_level_held", key_level, 2'b01);
    tick(5);
    key_n[0] = 1'b1;
    push(cyc + DB + 2, 0, K_REL);
    tick(7);
    #1 chk("long_level_released", key_level, 2'b00);

    // Release bounce while held: two high samples delay key_long by two.
    tick(2);
    k = cyc;
    key_n[0] = 1'b0;
    p = k + DB + 2;
    push(p, 0, K_PRESS);
    push(p + LG + 2, 0, K_LONG);
    tick(8);
    key_n[0] = 1'b1;
    tick(2);
    key_n[0] = 1'b0;
    tick(4);
    #1 chk("relbounce_level", key_level, 2'b01);
    tick(7);
    key_n[0] = 1'b1;
    push(cyc + DB + 2, 0, K_REL);
    tick(7);
    #1 chk("relbounce_released", key_level, 2'b00);

    // Reset while the press check holds a count of three.
    tick(2);
    k = cyc;
    key_n[0] = 1'b0;
    tick(5);
    rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    tick(2);
    rst_n = 1'b1;
    m = cyc;
    push(m + DB + 2, 0, K_PRESS);
    tick(5);
    #1 chk("midreset_level_before", key_level, 2'b00);
    tick(1);
    #1 chk("midreset_level_pressed", key_level, 2'b01);
    tick(1);
    key_n[0] = 1'b1;
    push(cyc + DB + 2, 0, K_REL);
    tick(7);
    #1 chk("midreset_released", key_level, 2'b00);

    // Both keys, key1 two cycles behind key0.
    tick(2);
    k = cyc;
    key_n[0] = 1'b0;
    push(k + DB + 2, 0, K_PRESS);
    tick(2);
    key_n[1] = 1'b0;
    push(k + DB + 4, 1, K_PRESS);
    tick(5);
    #1 chk("indep_level_k0", key_level, 2'b01);
    tick(2);
    #1 chk("indep_level_both", key_level, 2'b11);
    key_n[0] = 1'b1;
    push(cyc + DB + 2, 0, K_REL);
    tick(1);
    key_n[1] = 1'b1;
    push(cyc + DB + 2, 1, K_REL);
    tick(7);
    #1 chk("indep_released", key_level, 2'b00);

    tick(20);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pulses_missing: got %0d outstanding expected pulses, expected 0 (next %s key%0d edge %0d)",
               exp_q.size(), kind_name(exp_q[0].kind), exp_q[0].key, exp_q[0].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
